stream_uart_tx: RTL and testbench
=================================

Name: stream_uart_tx

Overview:
Hardware 8N1 UART transmitter with a byte-wide AXI4-Stream slave input. Sits directly downstream of corescorecore, consuming its o_tdata/o_tlast/o_tvalid/i_tready stream, and drives the board UART pin. Lets boards report scores without a soft-core emitter and its firmware image. Buffers bursts in an internal FIFO so the upstream stream stalls only when the FIFO is full.

Parameters:
BAUD_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous, active-low reset
i_tdata  input  8  stream byte
i_tlast  input  1  last byte of message
i_tvalid  input  1  stream valid
o_tready  output  1  stream ready (FIFO not full)
o_uart_tx  output  1  serial line, idle high
o_busy  output  1  high while a frame is on the line or the FIFO is non-empty

Behaviour:
- Reset (async assert, sync-released by the surrounding design): FIFO empty, FSM IDLE, o_uart_tx=1, o_tready=1, o_busy=0, baud counter=0.
- Handshake: a byte is accepted on a rising edge with i_tvalid && o_tready. o_tready = !full and is independent of i_tvalid. An entry stores {tlast, data}, 9 bits.
- Full boundary: a pop does not free space until the following cycle, so no same-cycle push-on-full.
- Empty boundary: a byte written into an empty FIFO becomes visible one cycle later.
- FSM IDLE -> START:
  - Taken when the FIFO is non-empty.
  - Pops the entry, loads the shift register, resets the baud counter.
  - o_uart_tx goes low at that edge.
  - Latency: byte accepted at edge N, so the start bit is driven from edge N+2 when the block is idle.
- START -> DATA -> STOP:
  - Each bit lasts exactly BAUD_DIV cycles. The baud counter counts 0..BAUD_DIV-1 and wraps.
  - DATA shifts out 8 bits LSB first, tracked by a 3-bit bit counter.
  - STOP drives 1 for one bit period.
- End of STOP: if the FIFO is non-empty, pop and enter START directly (no idle cycle). Back-to-back frames are therefore exactly 10*BAUD_DIV cycles apart. Otherwise go to IDLE.
- Counter widths: baud counter $clog2(BAUD_DIV) bits; FIFO count FIFO_AW+1 bits. Pointers wrap modulo depth.
- Data are never dropped or reordered; output byte order equals acceptance order.
- Reset mid-frame: o_uart_tx returns high immediately (async). The FIFO is flushed. The partial frame is not resumed.
- i_tlast is stored but has no line effect unless the optional feature is compiled in.

Optional Feature:
Macro STREAM_UART_TX_NEWLINE_EN.
- Defined:
  - After the STOP bit of a byte stored with tlast=1, one additional 8N1 frame carrying 0x0A is sent without popping the FIFO.
  - Implemented via a pending-newline flag and the path STOP -> START with the shift register loaded with 0x0A.
  - The flag is cleared by reset.
  - o_busy stays high through the newline frame.
- Undefined: tlast is ignored; the flag logic is absent.

Decomposition:
- Package corescore_uart_pkg:
  - FSM state enum {IDLE, START, DATA, STOP}.
  - DATA_BITS=8.
  - NEWLINE_CHAR=8'h0A.
- Sub-module stream_fifo:
  - Synchronous, parameterised width/FIFO_AW, async active-low reset.
  - Ports: push, pop, full, empty, data.
  - Reused wherever a stream buffer is needed.
- The top contains the FSM, baud counter and shift register.

Test Plan:
- Reset: hold i_rst_n=0 for 5 cycles, then release -> o_uart_tx=1, o_tready=1, o_busy=0; line stays high for 100 idle cycles.
- Single byte (BAUD_DIV=4): accept 0x55 at edge N -> o_uart_tx low from edge N+2 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then stop high; frame = 40 cycles; o_busy falls after stop.
- Back-pressure (BAUD_DIV=4, FIFO_AW=4): hold i_tvalid=1 with 20 incrementing bytes from idle -> o_tready deasserts after 17 accepts (16 stored + 1 in flight); reasserts the cycle after the next pop; all 20 bytes appear in order, start bits spaced exactly 40 cycles.
- Reset mid-frame: assert i_rst_n=0 during data bit 3 of 0xA5 with 5 bytes queued -> o_uart_tx=1 in the same cycle; after release o_tready=1, o_busy=0, no further frames.
- Newline (macro defined): send 0x41 with tlast=1 -> frames 0x41 then 0x0A back-to-back (80 cycles). With the macro undefined, only 0x41 is sent.
- Gapped input: bytes 0x31, 0x32 with 100-cycle i_tvalid gaps -> each frame starts 2 cycles after its accept; the line is idle-high between frames.

Source files
------------

// File: rtl/stream_uart_tx_pkg.sv
// corescore_uart_pkg: shared types/constants for the stream UART transmitter.
// FSM states, frame width, newline character, FIFO entry layout.
package corescore_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int DATA_BITS = 8;
  localparam logic [7:0] NEWLINE_CHAR = 8'h0A;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/stream_uart_tx_if.sv
// stream_uart_tx_if: byte-wide AXI4-Stream link (tdata/tlast/tvalid/tready).
// master drives data/valid, slave drives ready.
interface stream_uart_tx_if;
  import corescore_uart_pkg::*;

  logic [DATA_BITS-1:0] i_tdata;
  logic                 i_tlast;
  logic                 i_tvalid;
  logic                 o_tready;

  modport master (
    output i_tdata,
    output i_tlast,
    output i_tvalid,
    input  o_tready
  );

  modport slave (
    input  i_tdata,
    input  i_tlast,
    input  i_tvalid,
    output o_tready
  );

endinterface

// File: rtl/stream_uart_tx_fifo.sv
// stream_fifo: sync FIFO, 2**FIFO_AW x WIDTH, async active-low reset.
// Ports: i_push/i_pop/i_data in; o_data/o_full/o_empty/o_count out.
module stream_fifo #(
  parameter int WIDTH   = 9,
  parameter int FIFO_AW = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [FIFO_AW:0] o_count
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] ONE_C = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] ONE_P = FIFO_AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q, wr_d;
  logic [FIFO_AW-1:0] rd_q, rd_d;
  logic [FIFO_AW:0] cnt_q, cnt_d;
  logic [FIFO_AW:0] vis_q, vis_d;
  logic seen_q;
  logic push_ok, pop_ok;

  // vis_q counts entries readable by the consumer; a push
  // joins it one cycle after it lands in cnt_q.
  assign o_full  = cnt_q == DEPTH_C;
  assign o_empty = vis_q == '0;
  assign o_count = cnt_q;
  assign o_data  = mem_q[rd_q];

  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    vis_d = vis_q;
    if (push_ok) begin
      wr_d  = wr_q + ONE_P;
      cnt_d = cnt_d + ONE_C;
    end
    if (pop_ok) begin
      rd_d  = rd_q + ONE_P;
      cnt_d = cnt_d - ONE_C;
      vis_d = vis_d - ONE_C;
    end
    if (seen_q) begin
      vis_d = vis_d + ONE_C;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      vis_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      vis_q  <= vis_d;
      seen_q <= push_ok;
    end
  end

endmodule

// File: rtl/stream_uart_tx.sv
// stream_uart_tx: 8N1 UART TX fed by a byte AXI-Stream slave (s_axis) via FIFO.
// Ports: i_clk, i_rst_n, s_axis, o_uart_tx, o_busy. Option: STREAM_UART_TX_NEWLINE_EN.
module stream_uart_tx
  import corescore_uart_pkg::*;
#(
  parameter int BAUD_DIV = 868,
  parameter int FIFO_AW  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  stream_uart_tx_if.slave    s_axis,
  output logic               o_uart_tx,
  output logic               o_busy
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BMAX = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BONE = BW'(1);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CLAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] CONE = CW'(1);

  tx_state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic tx_q, tx_d;
  logic tick;

  logic fifo_push, fifo_pop;
  logic fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_cnt;
  entry_t wr_ent, rd_ent;

  assign s_axis.o_tready = !fifo_full;
  assign fifo_push = s_axis.i_tvalid && !fifo_full;
  assign wr_ent.last = s_axis.i_tlast;
  assign wr_ent.data = s_axis.i_tdata;

  stream_fifo #(
    .WIDTH   (ENTRY_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fifo_push),
    .i_pop   (fifo_pop),
    .i_data  (wr_ent),
    .o_data  (rd_ent),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_cnt)
  );

`ifdef STREAM_UART_TX_NEWLINE_EN
  logic nl_q, nl_d;
`else
  logic unused_tlast;
  assign unused_tlast = rd_ent.last;
`endif

  assign tick = baud_q == BMAX;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
`ifdef STREAM_UART_TX_NEWLINE_EN
    nl_d     = nl_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = rd_ent.data;
          baud_d   = '0;
          tx_d     = 1'b0;
          state_d  = START;
`ifdef STREAM_UART_TX_NEWLINE_EN
          nl_d     = rd_ent.last;
`endif
        end
      end
      START: begin
        if (tick) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = sh_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BONE;
        end
      end
      DATA: begin
        if (tick) begin
          baud_d = '0;
          if (bit_q == CLAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + CONE;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end else begin
          baud_d = baud_q + BONE;
        end
      end
      STOP: begin
        if (tick) begin
          baud_d = '0;
          // Chain straight into the next start bit when
          // more work is waiting, so frames stay gapless.
`ifdef STREAM_UART_TX_NEWLINE_EN
          if (nl_q) begin
            nl_d    = 1'b0;
            sh_d    = NEWLINE_CHAR;
            tx_d    = 1'b0;
            state_d = START;
          end else
`endif
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sh_d     = rd_ent.data;
            tx_d     = 1'b0;
            state_d  = START;
`ifdef STREAM_UART_TX_NEWLINE_EN
            nl_d     = rd_ent.last;
`endif
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BONE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

`ifdef STREAM_UART_TX_NEWLINE_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      nl_q <= 1'b0;
    end else begin
      nl_q <= nl_d;
    end
  end
`endif

  assign o_uart_tx = tx_q;
  assign o_busy    = (state_q != IDLE) || (fifo_cnt != '0);

endmodule

// File: tb/tb_stream_uart_tx.sv
// tb_stream_uart_tx: scoreboard bench; a line monitor decodes 8N1 frames
// and checks them against bytes queued at acceptance.
module tb_stream_uart_tx;

  localparam int B     = 4;
  localparam int AW    = 4;
  localparam int FRAME = 10 * B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx, busy;

  stream_uart_tx_if bus();

  stream_uart_tx #(
    .BAUD_DIV (B),
    .FIFO_AW  (AW)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .s_axis    (bus),
    .o_uart_tx (tx),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int frames = 0;
  logic [7:0] exp_q[$];
  int starts_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, req, cyc);
    end
  endtask

  // Reference: each accepted byte yields one frame; a tlast byte
  // adds a newline frame when the option is built in.
  task automatic push_exp(input logic [7:0] d, input logic l);
    exp_q.push_back(d);
`ifdef STREAM_UART_TX_NEWLINE_EN
    if (l) exp_q.push_back(8'h0A);
`else
    if (l) begin end
`endif
  endtask

  // Line monitor: 10 bits x B samples per frame.
  initial begin : mon
    logic [9:0] fr;
    logic ok, ab;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        starts_q.push_back(cyc);
        fr = '0;
        ok = 1'b1;
        ab = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < B; s++) begin
            if (!(b == 0 && s == 0)) @(negedge clk);
            if (!rst_n) begin
              ab = 1'b1;
              break;
            end
            if (s == 0) fr[b] = tx;
            else if (tx !== fr[b]) ok = 1'b0;
          end
          if (ab) break;
        end
        if (!ab) begin
          frames++;
          if (exp_q.size() == 0) begin
            chk("frame_unexpected", {22'd0, fr}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("frame", {21'd0, ok, fr},
                {21'd0, 1'b1, 1'b1, e, 1'b0});
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l,
                      output int acc);
    int n;
    n = 0;
    @(negedge clk);
    bus.i_tdata  = d;
    bus.i_tlast  = l;
    bus.i_tvalid = 1'b1;
    while (!bus.o_tready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      chk("send_timeout", 32'd1, 32'd0);
      acc = -1;
      bus.i_tvalid = 1'b0;
      return;
    end
    acc = cyc + 1;
    push_exp(d, l);
    @(posedge clk);
    #1;
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input int lim);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(n < lim), 32'd1);
  endtask

  task automatic chk_start(input string nm, input int idx,
                           input int want);
    if (starts_q.size() > idx) chk(nm, starts_q[idx], want);
    else chk({nm, "_missing"}, 32'(starts_q.size()), 32'(idx + 1));
  endtask

  initial begin : main
    int acc, acc0, n0, lows, nst, re, i, f0, sb, gap;
    logic [7:0] d;
    logic l;

    bus.i_tdata  = '0;
    bus.i_tlast  = 1'b0;
    bus.i_tvalid = 1'b0;

    // Reset
    repeat (5) @(negedge clk);
    chk("rst_tx", tx, 1);
    rst_n = 1'b1;
    #1;
    chk("rst_tx_rel", tx, 1);
    chk("rst_tready", bus.o_tready, 1);
    chk("rst_busy", busy, 0);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("idle_line", lows, 0);

    // Single byte 0x55
    n0 = starts_q.size();
    send(8'h55, 1'b0, acc);
    while (cyc < acc + 2 + FRAME - 1) @(negedge clk);
    chk("busy_in_stop", busy, 1);
    @(negedge clk);
    chk("busy_fall", busy, 0);
    wait_drain(1000);
    chk_start("start_55", n0, acc + 2);

    // Gapped input
    for (int k = 0; k < 2; k++) begin
      n0 = starts_q.size();
      d = 8'h31 + 8'(k);
      send(d, 1'b0, acc);
      repeat (100) @(negedge clk);
      chk_start("start_gap", n0, acc + 2);
    end
    wait_drain(1000);

    // Back-pressure: 20 incrementing bytes, valid held high
    n0 = starts_q.size();
    @(negedge clk);
    bus.i_tvalid = 1'b1;
    i = 0; nst = -1; re = -1; acc0 = -1; gap = 0;
    while (i < 20 && gap < 3000) begin
      d = 8'h10 + 8'(i);
      bus.i_tdata = d;
      if (bus.o_tready) begin
        if (nst >= 0 && re < 0) re = cyc;
        if (i == 0) acc0 = cyc + 1;
        push_exp(d, 1'b0);
        i++;
      end else if (nst < 0) begin
        nst = i;
      end
      @(negedge clk);
      gap++;
    end
    bus.i_tvalid = 1'b0;
    chk("bp_accepts_before_stall", nst, 17);
    chk("bp_reassert", re, acc0 + 2 + FRAME);
    wait_drain(5000);
    chk("bp_frames", starts_q.size() - n0, 20);
    sb = 0;
    for (int k = 1; k < 20; k++) begin
      if (starts_q.size() > n0 + k &&
          starts_q[n0+k] - starts_q[n0+k-1] != FRAME) sb++;
    end
    chk("bp_spacing", sb, 0);

    // Newline option
    n0 = starts_q.size();
    send(8'h41, 1'b1, acc);
    wait_drain(2000);
    chk_start("start_41", n0, acc + 2);
`ifdef STREAM_UART_TX_NEWLINE_EN
    chk("nl_frames", starts_q.size() - n0, 2);
    chk_start("nl_b2b", n0 + 1, acc + 2 + FRAME);
`else
    chk("nl_frames", starts_q.size() - n0, 1);
`endif

    // Randomised traffic
    for (int k = 0; k < 40; k++) begin
      d = 8'($urandom);
      l = ($urandom_range(0, 3) == 0);
      send(d, l, acc);
      gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 80) : 0;
      repeat (gap) @(negedge clk);
    end
    wait_drain(20000);

    // Reset mid-frame during data bit 3 of 0xA5
    send(8'hA5, 1'b0, acc);
    for (int k = 0; k < 5; k++) begin
      d = 8'hC0 + 8'(k);
      send(d, 1'b0, acc0);
    end
    while (cyc < acc + 2 + 4 * B + 1) @(negedge clk);
    chk("pre_rst_bit3", tx, 0);
    f0 = frames;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", tx, 1);
    repeat (5) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    #1;
    chk("rst_mid_tready", bus.o_tready, 1);
    chk("rst_mid_busy", busy, 0);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("rst_mid_idle", lows, 0);
    chk("rst_mid_frames", frames - f0, 0);
    chk("exp_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
